// File: rtl/common_pkg.sv
// Shared bus-level definitions for the Wishbone initiator and the SPI command
// decoder that drives it.
package common_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 20;
  localparam int unsigned DATA_WIDTH    = 32;

  // Single-word command as issued by the SPI decoder.
  typedef struct packed {
    logic                     we;
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } wb_cmd_t;

  // Response returned to the SPI decoder; err=1 marks a watchdog abort.
  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } wb_rsp_t;

endpackage

// File: rtl/wb_initiator.sv
// Wishbone B4 pipelined initiator: one single-word transaction per accepted
// command, at most one outstanding, with a watchdog that aborts transactions
// whose peripheral never acknowledges.
module wb_initiator
  import common_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 31,
  parameter int unsigned ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int unsigned DW             = DATA_WIDTH
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DW-1:0]         cmd_data_i,
  output logic                  rsp_valid_o,
  output logic [DW-1:0]         rsp_data_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] wbc_addr_o,
  output logic [DW-1:0]         wbc_data_o,
  input  logic [DW-1:0]         wbc_data_i,
  output logic                  wbc_we_o,
  output logic                  wbc_cycle_o,
  output logic                  wbc_strobe_o,
  input  logic                  wbc_stall_i,
  input  logic                  wbc_ack_i
);

  // One-hot so cmd_ready_o is a single register bit decode.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'b001,
    ST_REQUEST  = 3'b010,
    ST_WAIT_ACK = 3'b100
  } state_e;

  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

  // Watchdog count saturates at the limit so it never wraps while waiting.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= TimeoutLimit) ? TimeoutLimit : v + 8'd1;
  endfunction

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;

  logic accept;
  logic in_txn;
  logic strobe_taken;
  logic ack_done;
  logic timed_out;

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rdata_q;
  assign rsp_err_o    = rsp_err_q;
  assign wbc_addr_o   = addr_q;
  assign wbc_data_o   = wdata_q;
  assign wbc_we_o     = we_q;
  assign wbc_cycle_o  = cyc_q;
  assign wbc_strobe_o = stb_q;

  // Next-state decode: accept, strobe handshake, completion and watchdog abort.
  always_comb begin
    accept       = (state_q == ST_IDLE) && cmd_valid_i;
    in_txn       = (state_q != ST_IDLE);
    strobe_taken = (state_q == ST_REQUEST) && !wbc_stall_i;
    // An ack only counts once the strobe has been (or is being) accepted;
    // in IDLE it is a stray and ignored.
    ack_done     = wbc_ack_i && (strobe_taken || (state_q == ST_WAIT_ACK));
    // Ack arriving on the timeout edge wins over the abort.
    timed_out    = in_txn && !ack_done && (cnt_q == TimeoutLimit);

    state_d     = state_q;
    cnt_d       = in_txn ? sat_inc(cnt_q) : cnt_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;

    if (accept) begin
      state_d = ST_REQUEST;
      cnt_d   = 8'd0;
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      we_d    = cmd_we_i;
      addr_d  = cmd_addr_i;
      wdata_d = cmd_data_i;
    end else if (ack_done) begin
      state_d     = ST_IDLE;
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b0;
      rdata_d     = we_q ? '0 : wbc_data_i;
    end else if (timed_out) begin
      state_d     = ST_IDLE;
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rdata_d     = '0;
    end else if (strobe_taken) begin
      state_d = ST_WAIT_ACK;
      stb_d   = 1'b0;
    end
  end

  // State and registered outputs; reset drops the bus cycle immediately.
  always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: the bench plays the Wishbone
// peripheral from a per-transaction plan (stall length, ack delay) and a
// transaction-level model predicts every output cycle by cycle.
module tb_wb_initiator;
  import common_pkg::*;

  localparam int T   = 31;
  localparam int AW  = WB_ADDR_WIDTH;
  localparam int DWL = DATA_WIDTH;
  localparam int BIG = 1000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid_i = 1'b0;
  logic           cmd_ready_o;
  logic           cmd_we_i = 1'b0;
  logic [AW-1:0]  cmd_addr_i = '0;
  logic [DWL-1:0] cmd_data_i = '0;
  logic           rsp_valid_o;
  logic [DWL-1:0] rsp_data_o;
  logic           rsp_err_o;
  logic [AW-1:0]  wbc_addr_o;
  logic [DWL-1:0] wbc_data_o;
  logic [DWL-1:0] wbc_data_i = '0;
  logic           wbc_we_o;
  logic           wbc_cycle_o;
  logic           wbc_strobe_o;
  logic           wbc_stall_i = 1'b0;
  logic           wbc_ack_i = 1'b0;

  wb_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clock_i  (clk),
    .wb_reset_n_i(rst_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_data_i  (cmd_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .wbc_addr_o  (wbc_addr_o),
    .wbc_data_o  (wbc_data_o),
    .wbc_data_i  (wbc_data_i),
    .wbc_we_o    (wbc_we_o),
    .wbc_cycle_o (wbc_cycle_o),
    .wbc_strobe_o(wbc_strobe_o),
    .wbc_stall_i (wbc_stall_i),
    .wbc_ack_i   (wbc_ack_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Transaction-level model: c = cycles since the accept edge.
  bit             active = 1'b0;
  int             c = 0;
  int             p_s = 0;
  int             p_a = 0;
  int             p_E = 0;
  bit             p_err = 1'b0;
  bit             p_we = 1'b0;
  logic [AW-1:0]  p_addr = '0;
  logic [DWL-1:0] p_data = '0;
  logic [DWL-1:0] p_rsp = '0;
  logic [DWL-1:0] held_rsp = '0;
  logic [DWL-1:0] mem [int];
  bit             chk_en = 1'b0;

  int             stb_cnt = 0;
  int             cyc_cnt = 0;
  int             rsp_cnt = 0;
  logic [DWL-1:0] last_data = '0;
  bit             last_err = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DWL-1:0] rd(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return '0;
  endfunction

  // Edge at which the transaction ends: the ack edge if it comes no later
  // than edge T+1 after accept, otherwise the watchdog fires at edge T+1.
  function automatic int end_edge(input int s, input int a);
    if (a >= 0 && s + a <= T) return s + a + 1;
    return T + 1;
  endfunction

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    bit cyc_e, stb_e, rv_e;
    int stb_end;
    if (!rst_n) begin
      held_rsp = '0;
    end else if (chk_en) begin
      stb_end = (p_s + 1 < p_E) ? p_s + 1 : p_E;
      cyc_e   = active && (c < p_E);
      stb_e   = active && (c < stb_end);
      rv_e    = active && (c == p_E);
      if (rv_e) held_rsp = p_rsp;
      chk("cycle", wbc_cycle_o, cyc_e);
      chk("strobe", wbc_strobe_o, stb_e);
      chk("cmd_ready", cmd_ready_o, !cyc_e);
      chk("rsp_valid", rsp_valid_o, rv_e);
      chk("wb_addr", wbc_addr_o, p_addr);
      chk("wb_wdata", wbc_data_o, p_data);
      chk("wb_we", wbc_we_o, p_we);
      chk("rsp_data", rsp_data_o, held_rsp);
      if (rv_e) chk("rsp_err", rsp_err_o, p_err);
      if (active && c == 0) begin
        stb_cnt = 0;
        cyc_cnt = 0;
      end
      if (wbc_cycle_o) cyc_cnt++;
      if (wbc_strobe_o) stb_cnt++;
      if (rsp_valid_o) begin
        rsp_cnt++;
        last_data = rsp_data_o;
        last_err  = rsp_err_o;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cmd_valid_i = 1'b0;
      cmd_we_i    = 1'($urandom);
      cmd_addr_i  = AW'($urandom);
      cmd_data_i  = DWL'($urandom);
      wbc_ack_i   = ($urandom_range(0, 3) == 0);
      wbc_stall_i = 1'($urandom);
      wbc_data_i  = DWL'($urandom);
      step();
    end
    wbc_ack_i = 1'b0;
  endtask

  // Issue one command and play the peripheral: stall s cycles, then ack
  // a cycles after strobe acceptance (a<0: never ack).
  task automatic txn(input bit we, input logic [AW-1:0] addr, input logic [DWL-1:0] data,
                     input int s, input int a, input int max_c);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_data_i  = data;
    wbc_ack_i   = 1'b0;
    wbc_stall_i = 1'($urandom);
    @(posedge clk);
    #1;
    p_we   = we;
    p_addr = addr;
    p_data = data;
    p_s    = s;
    p_a    = a;
    p_E    = end_edge(s, a);
    p_err  = !(a >= 0 && s + a <= T);
    p_rsp  = (p_err || we) ? '0 : rd(addr);
    c      = 0;
    active = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'($urandom);
    cmd_addr_i  = AW'($urandom);
    cmd_data_i  = DWL'($urandom);
    while (c < p_E && c < max_c) begin
      wbc_stall_i = (c < s) ? 1'b1 : (c == s) ? 1'b0 : 1'($urandom);
      wbc_ack_i   = (a >= 0 && c == s + a);
      wbc_data_i  = (wbc_ack_i && !we) ? rd(addr) : DWL'($urandom);
      step();
    end
    wbc_ack_i   = 1'b0;
    wbc_stall_i = 1'b0;
    if (we && !p_err && c >= p_E) mem[int'(addr)] = data;
  endtask

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", cmd_ready_o, 1);
    chk("reset_cycle", wbc_cycle_o, 0);
    chk("reset_rsp_valid", rsp_valid_o, 0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Read from preloaded RAM location.
    mem[int'(20'h01234)] = 32'hA5;
    txn(1'b0, 20'h01234, '0, 0, 1, BIG);
    idle(1);
    chk("read_data_lit", last_data, 32'hA5);
    chk("read_err_lit", last_err, 0);
    chk("read_strobe_cycles", stb_cnt, 1);
    chk("read_rsp_count", rsp_cnt, 1);

    // Write then read back.
    txn(1'b1, 20'h00010, 32'h5A, 0, 0, BIG);
    idle(1);
    chk("write_data_lit", last_data, 0);
    chk("write_err_lit", last_err, 0);
    txn(1'b0, 20'h00010, '0, 1, 2, BIG);
    idle(1);
    chk("readback_lit", last_data, 32'h5A);

    // Stall for three cycles: strobe visible four cycles, one response.
    n0 = rsp_cnt;
    txn(1'b1, 20'h00020, 32'hDEAD_BEEF, 3, 1, BIG);
    idle(1);
    chk("stall_strobe_cycles", stb_cnt, 4);
    chk("stall_single_rsp", rsp_cnt - n0, 1);

    // No responder: watchdog abort, then a normal command.
    txn(1'b0, 20'h00030, '0, 0, -1, BIG);
    idle(1);
    chk("timeout_cycle_len", cyc_cnt, 32);
    chk("timeout_err_lit", last_err, 1);
    chk("timeout_data_lit", last_data, 0);
    txn(1'b0, 20'h01234, '0, 0, 0, BIG);
    idle(1);
    chk("after_timeout_lit", last_data, 32'hA5);

    // Ack exactly on the timeout edge wins; one edge later loses.
    txn(1'b0, 20'h01234, '0, 2, 29, BIG);
    idle(1);
    chk("ack_at_timeout_err", last_err, 0);
    chk("ack_at_timeout_data", last_data, 32'hA5);
    txn(1'b0, 20'h01234, '0, 0, 32, BIG);
    idle(1);
    chk("ack_late_err", last_err, 1);

    // Randomized traffic, including back-to-back commands and stray acks.
    for (int i = 0; i < 80; i++) begin
      int s, a;
      s = $urandom_range(0, 4);
      a = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 6);
      txn(1'($urandom), AW'($urandom_range(0, 7)), DWL'($urandom), s, a, BIG);
      idle($urandom_range(0, 2));
    end

    // Reset while waiting for an ack; a late ack must be ignored.
    mem[5] = 32'h1234_5678;
    txn(1'b0, 20'h00005, '0, 0, -1, 3);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cycle", wbc_cycle_o, 0);
    chk("rst_mid_strobe", wbc_strobe_o, 0);
    chk("rst_mid_ready", cmd_ready_o, 1);
    chk("rst_mid_rsp_valid", rsp_valid_o, 0);
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    active = 1'b0;
    p_we   = 1'b0;
    p_addr = '0;
    p_data = '0;
    n0     = rsp_cnt;
    chk_en = 1'b1;
    wbc_ack_i  = 1'b1;
    wbc_data_i = 32'hFFFF_FFFF;
    step();
    wbc_ack_i = 1'b0;
    idle(3);
    chk("late_ack_no_rsp", rsp_cnt, n0);
    txn(1'b0, 20'h00005, '0, 1, 1, BIG);
    idle(1);
    chk("post_reset_read", last_data, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
